// File: rtl/display_writer_pkg.sv
// Shared constants, state encoding and DIN packing for the display RAM writer.
package display_writer_pkg;

    localparam int          NDIGITS        = 8;
    localparam int          DIN_EN         = 5;
    localparam int          DIN_BCD_HI     = 4;
    localparam int          DIN_BCD_LO     = 1;
    localparam int          DIN_DP         = 0;
    localparam int unsigned MAX_VALUE_DFLT = 99_999_999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [5:0] pack_din(input logic en, input logic [3:0] digit, input logic dp);
        logic [5:0] d;
        d                        = '0;
        d[DIN_EN]                = en;
        d[DIN_BCD_HI:DIN_BCD_LO] = digit;
        d[DIN_DP]                = dp;
        return d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, VALUE_W steps per load.
// bcd/valid look ahead to the result of the current step so the caller can act on the final edge.
module bin_to_bcd_seq
    import display_writer_pkg::*;
#(
    parameter int VALUE_W = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [VALUE_W-1:0] bin,
    output logic [31:0]        bcd,
    output logic               valid
);

    localparam int CW = $clog2(VALUE_W);

    logic [VALUE_W-1:0]    sh_r, sh_n;
    logic [31:0]           bcd_r, adj;
    logic [31+VALUE_W:0]   cat;
    logic [CW-1:0]         cnt;
    logic                  run;

    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
        cat   = {adj, sh_r} << 1;
        bcd   = cat[31+VALUE_W -: 32];
        sh_n  = cat[VALUE_W-1:0];
        valid = run && (cnt == CW'(VALUE_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_r  <= '0;
            bcd_r <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (load) begin
            sh_r  <= bin;
            bcd_r <= '0;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            sh_r  <= sh_n;
            bcd_r <= bcd;
            cnt   <= cnt + 1'b1;
            if (valid)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/display_writer.sv
// Converts a binary value to 8 BCD digits and writes them, LSD first, into the display RAM.
module display_writer
    import display_writer_pkg::*;
#(
    parameter int          VALUE_W   = 27,
    parameter int unsigned MAX_VALUE = MAX_VALUE_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    input  logic [7:0]         dp_mask,
    input  logic               blank_lz,
    output logic               W,
    output logic [2:0]         WADD,
    output logic [5:0]         DIN,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    state_t       state, state_nxt;
    logic         accept, cvt_last, blz_r, any;
    logic [7:0]   dp_r, en_r, en_c;
    logic [31:0]  bcd_seq, fin, res;
    logic [2:0]   widx;

    bin_to_bcd_seq #(.VALUE_W(VALUE_W)) u_b2b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .bin   (value),
        .bcd   (bcd_seq),
        .valid (cvt_last)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:    if (start) begin accept = 1'b1; state_nxt = CONVERT; end
            CONVERT: if (cvt_last) state_nxt = WRITE;
            WRITE:   if (WADD == 3'd7) state_nxt = DONE;
            DONE: begin
                if (start) begin accept = 1'b1; state_nxt = CONVERT; end
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturation and leading-zero enables, evaluated on the final conversion step.
    always_comb begin
        fin  = ovf ? {NDIGITS{4'h9}} : bcd_seq;
        any  = 1'b0;
        en_c = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            any     = any | (fin[4*i +: 4] != 4'h0);
            en_c[i] = !blz_r || (i == 0) || any;
        end
        widx = WADD + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            W     <= 1'b0;
            WADD  <= '0;
            DIN   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            dp_r  <= '0;
            blz_r <= 1'b0;
            en_r  <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CONVERT) || (state_nxt == WRITE);
            done  <= (state_nxt == DONE);
            W     <= (state_nxt == WRITE);
            if (accept) begin
                ovf   <= (value > VALUE_W'(MAX_VALUE));
                dp_r  <= dp_mask;
                blz_r <= blank_lz;
            end
            if (state == CONVERT && cvt_last) begin
                res  <= fin;
                en_r <= en_c;
                WADD <= 3'd0;
                DIN  <= pack_din(en_c[0], fin[3:0], dp_r[0]);
            end else if (state == WRITE && WADD != 3'd7) begin
                WADD <= widx;
                DIN  <= pack_din(en_r[widx], res[4*widx +: 4], dp_r[widx]);
            end
        end
    end

endmodule
